// File: rtl/vga_layer_regs.sv
// rtl/vga_layer_regs.sv - AXI4-Lite staged register bank for the VGA layer pipeline.
// Staging regs reach active_regs only on a frame_start after a commit request.
module vga_layer_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 8
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  input  logic                                frame_start,
  output logic [(NUM_REGS-2)*32-1:0]          active_regs,
  output logic                                irq
);

  localparam int DATA_W = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int NDATA  = NUM_REGS - 2;
  localparam int ACT_W  = NDATA * 32;

  localparam logic [IDX_W-1:0] IDX_CTRL   = '0;
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W:0]   NREG_X     = (IDX_W + 1)'(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write channel
  logic              awready_q, awready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [STRB_W-1:0] wr_strb_q, wr_strb_d;

  // Read channel
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;

  // Register state
  logic [ACT_W-1:0]  staging_q, staging_d;
  logic [ACT_W-1:0]  active_q, active_d;
  logic              pending_q, pending_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_flag_q, irq_flag_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              wr_ok, wr_en, rd_ok, commit;
  logic [DATA_W-1:0] rd_word;

  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign wr_ok  = ({1'b0, wr_idx_q} < NREG_X);
  assign rd_ok  = ({1'b0, rd_idx_q} < NREG_X);
  // The register update lands on the clock edge that ends the awready pulse.
  assign wr_en  = awready_q & wr_ok;
  assign commit = frame_start & pending_q;

  always_comb begin
    awready_d = s00_axi_awvalid & s00_axi_wvalid & ~awready_q & ~bvalid_q;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (awready_d) begin
      wr_idx_d  = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      wr_data_d = s00_axi_wdata;
      wr_strb_d = s00_axi_wstrb;
    end
    if (awready_q) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_idx_q == IDX_CTRL) begin
      rd_word = {30'd0, irq_en_q, pending_q};
    end else if (rd_idx_q == IDX_STATUS) begin
      rd_word = {irq_flag_q, 15'd0, frame_cnt_q};
    end else begin
      for (int k = 1; k <= NDATA; k++) begin
        if (rd_idx_q == IDX_W'(k)) rd_word = staging_q[32*(k-1) +: 32];
      end
    end
  end

  always_comb begin
    arready_d = s00_axi_arvalid & ~arready_q & ~rvalid_q;
    rd_idx_d  = arready_d ? s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2] : rd_idx_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? rd_word : '0;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Commit samples pre-write staging; a same-cycle COMMIT write re-arms pending
  // and a same-cycle commit beats the irq_flag clear.
  always_comb begin
    staging_d   = staging_q;
    active_d    = active_q;
    pending_d   = pending_q;
    irq_en_d    = irq_en_q;
    irq_flag_d  = irq_flag_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_start) frame_cnt_d = frame_cnt_q + 16'd1;
    if (commit) begin
      active_d   = staging_q;
      pending_d  = 1'b0;
      irq_flag_d = 1'b1;
    end
    if (wr_en) begin
      if (wr_idx_q == IDX_CTRL) begin
        if (wr_strb_q[0]) begin
          if (wr_data_q[0]) pending_d = 1'b1;
          irq_en_d = wr_data_q[1];
        end
      end else if (wr_idx_q == IDX_STATUS) begin
        if (wr_strb_q[3] && wr_data_q[31] && !commit) irq_flag_d = 1'b0;
      end else begin
        for (int k = 1; k <= NDATA; k++) begin
          if (wr_idx_q == IDX_W'(k)) begin
            for (int b = 0; b < 4; b++) begin
              if (wr_strb_q[b]) staging_d[32*(k-1) + 8*b +: 8] = wr_data_q[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      awready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      wr_strb_q   <= '0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      rd_idx_q    <= '0;
      staging_q   <= '0;
      active_q    <= '0;
      pending_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_flag_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      awready_q   <= awready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      wr_strb_q   <= wr_strb_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      rd_idx_q    <= rd_idx_d;
      staging_q   <= staging_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      irq_en_q    <= irq_en_d;
      irq_flag_q  <= irq_flag_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = awready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rdata   = rdata_q;
  assign active_regs     = active_q;
  assign irq             = irq_flag_q & irq_en_q;

endmodule

// File: tb/tb_vga_layer_regs.sv
// tb/tb_vga_layer_regs.sv - directed self-checking bench for vga_layer_regs.
module tb_vga_layer_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [5:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        frame_start = 1'b0;
  logic [191:0] active_regs;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  vga_layer_regs dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .frame_start(frame_start), .active_regs(active_regs),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // fs=1 raises frame_start on the same edge that performs the register update.
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit fs, output logic [1:0] resp);
    int n;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
    if (!awready) begin
      n_checks++; n_fail++;
      $display("FAIL write_awready_timeout addr=%h", addr);
    end
    if (fs) frame_start = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!bvalid) begin
      n_checks++; n_fail++;
      $display("FAIL write_bvalid_timeout addr=%h", addr);
    end
    resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
    if (!arready) begin
      n_checks++; n_fail++;
      $display("FAIL read_arready_timeout addr=%h", addr);
    end
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!rvalid) begin
      n_checks++; n_fail++;
      $display("FAIL read_rvalid_timeout addr=%h", addr);
    end
    data = rdata; resp = rresp;
    @(posedge clk); #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({awready, wready, bvalid, arready, rvalid, irq} !== 6'b0) begin
      n_fail++; $display("FAIL reset_handshake got=%b want=000000", {awready, wready, bvalid, arready, rvalid, irq});
    end
    n_checks++;
    if ({rdata, bresp, rresp} !== 36'h0) begin
      n_fail++; $display("FAIL reset_data got rdata=%h bresp=%b rresp=%b want 0", rdata, bresp, rresp);
    end
    n_checks++;
    if (active_regs !== '0) begin
      n_fail++; $display("FAIL reset_active got=%h want=0", active_regs);
    end
    apply_reset();
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic [1:0] r;
    axi_write(6'h04, 32'h11223344, 4'hF, 1'b0, r);
    n_checks++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL wr_reg1_bresp got=%b want=00", r); end
    axi_read(6'h04, d, r);
    n_checks++;
    if (d !== 32'h11223344 || r !== 2'b00) begin
      n_fail++; $display("FAIL rd_reg1 got=%h/%b want=11223344/00", d, r);
    end
    n_checks++;
    if (active_regs[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL active_before_commit got=%h want=0", active_regs[31:0]);
    end
  endtask

  task automatic test_commit();
    logic [31:0] d; logic [1:0] r;
    axi_write(6'h00, 32'h3, 4'hF, 1'b0, r);
    axi_read(6'h00, d, r);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL ctrl_pending got=%h want=00000003", d); end
    n_checks++;
    if (active_regs[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL active_pending_no_frame got=%h want=0", active_regs[31:0]);
    end
    pulse_frame();
    n_checks++;
    if (active_regs[31:0] !== 32'h11223344) begin
      n_fail++; $display("FAIL active_after_commit got=%h want=11223344", active_regs[31:0]);
    end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_commit got=%b want=1", irq); end
    axi_read(6'h00, d, r);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL ctrl_after_commit got=%h want=00000002", d); end
    axi_read(6'h1C, d, r);
    n_checks++;
    if (d !== 32'h80000001) begin n_fail++; $display("FAIL status_after_commit got=%h want=80000001", d); end
    axi_write(6'h1C, 32'h80000000, 4'hF, 1'b0, r);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_w1c got=%b want=0", irq); end
    axi_read(6'h1C, d, r);
    n_checks++;
    if (d !== 32'h00000001) begin n_fail++; $display("FAIL status_after_w1c got=%h want=00000001", d); end
  endtask

  task automatic test_wstrb();
    logic [31:0] d; logic [1:0] r;
    axi_write(6'h08, 32'hFFFFFFFF, 4'hF, 1'b0, r);
    axi_write(6'h08, 32'h000000AB, 4'h1, 1'b0, r);
    axi_read(6'h08, d, r);
    n_checks++;
    if (d !== 32'hFFFFFFAB) begin n_fail++; $display("FAIL wstrb_byte0 got=%h want=FFFFFFAB", d); end
    axi_write(6'h08, 32'h12345678, 4'hA, 1'b0, r);
    axi_read(6'h08, d, r);
    n_checks++;
    if (d !== 32'h12FF56AB) begin n_fail++; $display("FAIL wstrb_bytes13 got=%h want=12FF56AB", d); end
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic [1:0] r;
    axi_write(6'h20, 32'hDEADBEEF, 4'hF, 1'b0, r);
    n_checks++;
    if (r !== 2'b10) begin n_fail++; $display("FAIL oob_bresp got=%b want=10", r); end
    axi_read(6'h20, d, r);
    n_checks++;
    if (d !== 32'h0 || r !== 2'b10) begin n_fail++; $display("FAIL oob_read got=%h/%b want=00000000/10", d, r); end
    axi_write(6'h3C, 32'h00000001, 4'hF, 1'b0, r);
    n_checks++;
    if (r !== 2'b10) begin n_fail++; $display("FAIL oob_top_bresp got=%b want=10", r); end
    axi_read(6'h04, d, r);
    n_checks++;
    if (d !== 32'h11223344) begin n_fail++; $display("FAIL oob_reg1_intact got=%h want=11223344", d); end
    axi_read(6'h00, d, r);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL oob_ctrl_intact got=%h want=00000002", d); end
  endtask

  task automatic test_frame_events();
    logic [31:0] d; logic [1:0] r;
    apply_reset();
    frame_start = 1'b1;
    repeat (65537) @(posedge clk);
    #1 frame_start = 1'b0;
    axi_read(6'h1C, d, r);
    n_checks++;
    if (d !== 32'h00000001) begin n_fail++; $display("FAIL frame_wrap got=%h want=00000001", d); end
    axi_write(6'h04, 32'hCAFEF00D, 4'hF, 1'b0, r);
    axi_write(6'h00, 32'h1, 4'hF, 1'b1, r);
    n_checks++;
    if (active_regs[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL commit_same_cycle_early got=%h want=0", active_regs[31:0]);
    end
    axi_read(6'h00, d, r);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL commit_same_cycle_pending got=%h want=00000001", d); end
    pulse_frame();
    n_checks++;
    if (active_regs[31:0] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL commit_next_frame got=%h want=CAFEF00D", active_regs[31:0]);
    end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked got=%b want=0", irq); end
    axi_write(6'h08, 32'h11111111, 4'hF, 1'b0, r);
    axi_write(6'h00, 32'h1, 4'hF, 1'b0, r);
    axi_write(6'h08, 32'h22222222, 4'hF, 1'b1, r);
    n_checks++;
    if (active_regs[63:32] !== 32'h11111111) begin
      n_fail++; $display("FAIL write_vs_commit_active got=%h want=11111111", active_regs[63:32]);
    end
    axi_read(6'h08, d, r);
    n_checks++;
    if (d !== 32'h22222222) begin n_fail++; $display("FAIL write_vs_commit_staged got=%h want=22222222", d); end
    axi_write(6'h00, 32'h1, 4'hF, 1'b0, r);
    axi_write(6'h1C, 32'h80000000, 4'hF, 1'b1, r);
    axi_read(6'h1C, d, r);
    n_checks++;
    if (d !== 32'h80000005) begin n_fail++; $display("FAIL set_beats_w1c got=%h want=80000005", d); end
    axi_write(6'h1C, 32'h80000000, 4'hF, 1'b0, r);
    axi_read(6'h1C, d, r);
    n_checks++;
    if (d !== 32'h00000005) begin n_fail++; $display("FAIL w1c_clear got=%h want=00000005", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r; int n; int bad;
    awaddr = 6'h0C; wdata = 32'hAAAA5555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bvalid !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL bvalid_hold got=%0d drops want=0", bad); end
    awaddr = 6'h0C; wdata = 32'h5A5A0F0F; awvalid = 1'b1; wvalid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (awready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL awready_blocked got=%0d highs want=0", bad); end
    bready = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
    n_checks++;
    if (awready !== 1'b1) begin n_fail++; $display("FAIL second_write_accept got=%b want=1", awready); end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bvalid && n < 20);
    @(posedge clk); #1;
    axi_read(6'h0C, d, r);
    n_checks++;
    if (d !== 32'h5A5A0F0F) begin n_fail++; $display("FAIL second_write_data got=%h want=5A5A0F0F", d); end
  endtask

  task automatic test_reset_mid_read();
    int n; int bad;
    araddr = 6'h04; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (rvalid !== 1'b1) begin n_fail++; $display("FAIL mid_read_rvalid got=%b want=1", rvalid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL async_reset_read got=%b/%h want=0/00000000", rvalid, rdata);
    end
    n_checks++;
    if (active_regs !== '0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_state got=%h/%b want=0/0", active_regs, irq);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rvalid !== 1'b0 || bvalid !== 1'b0 || arready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL no_response_after_reset got=%0d want=0", bad); end
    rready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_commit();
    test_wstrb();
    test_slverr();
    test_frame_events();
    test_back_to_back();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
